cnu_row_scheduler: RTL and testbench
====================================

Name: cnu_row_scheduler

Overview:
- Sequences the pipelined check-node message generator across all check rows of the parity-check matrix, one decoding iteration at a time.
- Issues row read addresses to the row memory and produces the matching valid strobe for the check-node input.
- Tracks in-flight rows through the fixed check-node latency and emits the write-back address/enable when each compressed message emerges.
- Accumulates per-row parity to terminate early on a zero syndrome, or stops at the max-iteration limit.

Parameters:
- NROWS, 64, check rows per iteration.
- AW, 6, row address width; NROWS <= 2**AW.
- CNU_LAT, 7, cycles from the check-node valid input to its registered message output.
- IW, 5, width of the iteration limit and counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- start  in  1  one-cycle request to begin decoding; sampled only in IDLE.
- max_iter  in  IW  iteration limit, sampled with start; 0 is treated as 1.
- hold  in  1  pauses row issue this cycle (memory port conflict).
- row_parity  in  1  syndrome bit of the row being written back; valid when wr_en=1.
- rd_en  out  1  row memory read strobe.
- rd_addr  out  AW  row index being read.
- cnu_vld  out  1  check-node input valid; rd_en delayed by 1 cycle.
- wr_en  out  1  compressed-message write-back strobe.
- wr_addr  out  AW  row index of the message being written.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- converged  out  1  1 = zero syndrome reached; held until the next accepted start.
- iter_count  out  IW  iterations completed; held until the next accepted start.

Behaviour:
- Reset (rst=0): state IDLE. All outputs are 0 and the in-flight shift register is cleared. Reset overrides all other inputs, including mid-issue or mid-drain.
- States and transitions:
  - IDLE: on start, latch max_iter (0 becomes 1), clear iter_count, converged and the syndrome accumulator, then go to ISSUE.
  - ISSUE: each cycle with hold=0, assert rd_en with rd_addr=row and increment row. With hold=1, rd_en=0 and row holds. After row NROWS-1 issues, go to DRAIN.
  - DRAIN: no reads. Wait until the in-flight register is empty, i.e. the cycle after the last wr_en. Then go to EVAL.
  - EVAL: increment iter_count.
    - If the accumulator is 0: set converged=1 and go to DONE.
    - Else if the new iter_count equals the latched limit: converged=0, go to DONE.
    - Otherwise clear the accumulator, reset row to 0, and go to ISSUE.
  - DONE: done=1 for one cycle, then IDLE.
- Timing:
  - cnu_vld at t+1 for rd_en at t.
  - wr_en/wr_addr at t+1+CNU_LAT, carrying the same address.
  - Implement as a (CNU_LAT+1)-deep valid+address shift register that advances every cycle regardless of hold or state.
- Syndrome accumulator: OR of row_parity on every wr_en cycle; cleared on start and on each new iteration.
- No overlap: iteration n+1 issues no read until every row of iteration n is written back. This is required for layered consistency.
- busy=1 in ISSUE, DRAIN, EVAL and DONE; 0 in IDLE.
- start while busy is ignored, and has no effect on max_iter or counters.
- hold is ignored outside ISSUE. hold asserted continuously stalls ISSUE indefinitely without error.
- Gaps created by hold in the rd_en sequence are reproduced exactly, shifted, in the wr_en sequence.
- rd_addr and wr_addr are 0 whenever their strobe is 0.

Test Plan:
- NROWS=4, CNU_LAT=7, start at cycle 0, max_iter=3, row_parity=0 → rd_en cycles 1-4 (addr 0..3); cnu_vld cycles 2-5; wr_en cycles 9-12 (addr 0..3); done at cycle 14; converged=1; iter_count=1.
- Same setup, row_parity=1 whenever wr_addr=2 → three iterations with no read overlapping a pending write; second iteration rd_en at cycles 14-17; done with converged=0 and iter_count=3.
- hold=1 during cycles 2-4 of the first issue → rd_addr 0 at cycle 1, 1..3 at cycles 5-7; wr_en at 9 and 13-15 with matching addresses; done at cycle 17.
- rst=0 at cycle 10 during drain → cycle 11: all outputs 0, state IDLE, no further wr_en; a new start decodes normally.
- max_iter=0 with row_parity=1 → exactly one iteration, done, converged=0, iter_count=1.
- start pulsed at cycle 6 while busy → ignored; sequence identical to the first scenario.

Source files
------------

// File: rtl/cnu_row_scheduler.sv
// cnu_row_scheduler
//
// Sequences the pipelined check-node message generator over every check row
// of the parity-check matrix, one decoding iteration at a time.
//
//   clk         single clock, rising edge
//   rst         synchronous, active-low reset
//   start       one-cycle request to begin decoding (sampled only in IDLE)
//   max_iter    iteration limit, sampled with start; 0 behaves as 1
//   hold        pauses row issue for this cycle (memory port conflict)
//   row_parity  syndrome bit of the row being written back (valid with wr_en)
//   rd_en       row memory read strobe
//   rd_addr     row being read (0 when rd_en=0)
//   cnu_vld     check-node input valid, rd_en delayed one cycle
//   wr_en       compressed-message write-back strobe
//   wr_addr     row being written back (0 when wr_en=0)
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   converged   zero syndrome reached; held until the next accepted start
//   iter_count  iterations completed; held until the next accepted start
module cnu_row_scheduler #(
    parameter int NROWS   = 64,
    parameter int AW      = 6,
    parameter int CNU_LAT = 7,
    parameter int IW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] max_iter,
    input  logic          hold,
    input  logic          row_parity,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          cnu_vld,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [IW-1:0] iter_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // One stage for the cnu_vld register plus CNU_LAT stages through the
    // check node; the last stage lines up with the emerging message.
    localparam int DEPTH = CNU_LAT + 1;

    logic [2:0]       state;
    logic [AW-1:0]    row;
    logic [IW-1:0]    limit;
    logic             syndrome;
    logic [DEPTH-1:0] vld_sr;
    logic [AW-1:0]    addr_sr [DEPTH];

    logic             last_row;
    logic             pipe_empty_next;
    logic [IW-1:0]    iter_next;

    assign last_row  = (row == AW'(NROWS - 1));
    assign iter_next = iter_count + IW'(1);

    // Every stage except the output one is clear: after this cycle's shift
    // nothing is in flight, so the final write-back is happening now.
    assign pipe_empty_next = (vld_sr[DEPTH-2:0] == '0);

    assign rd_en   = (state == S_ISSUE) && !hold;
    assign rd_addr = rd_en ? row : '0;
    assign cnu_vld = vld_sr[0];
    assign wr_en   = vld_sr[DEPTH-1];
    // Address stages only ever capture a gated rd_addr, so this is already 0
    // whenever wr_en is 0.
    assign wr_addr = addr_sr[DEPTH-1];
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // NOTE: all state updates below use non-blocking assignments so every
    // register samples the pre-edge values, exactly as the flops will.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            row        <= '0;
            limit      <= '0;
            syndrome   <= 1'b0;
            converged  <= 1'b0;
            iter_count <= '0;
            vld_sr     <= '0;
            // NOTE: the address pipeline is reset too (unlike a data RAM),
            // because wr_addr must read 0 immediately after reset.
            for (int i = 0; i < DEPTH; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            // In-flight tracking advances every cycle, independent of state
            // and hold, so hold gaps reappear unchanged on the write side.
            vld_sr     <= {vld_sr[DEPTH-2:0], rd_en};
            addr_sr[0] <= rd_addr;
            for (int i = 1; i < DEPTH; i++) begin
                addr_sr[i] <= addr_sr[i-1];
            end

            if (wr_en && row_parity) begin
                syndrome <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        limit      <= (max_iter == '0) ? IW'(1) : max_iter;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        syndrome   <= 1'b0;
                        row        <= '0;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (!hold) begin
                        if (last_row) begin
                            row   <= '0;
                            state <= S_DRAIN;
                        end else begin
                            row <= row + AW'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (pipe_empty_next) begin
                        state <= S_EVAL;
                    end
                end

                S_EVAL: begin
                    iter_count <= iter_next;
                    if (!syndrome) begin
                        converged <= 1'b1;
                        state     <= S_DONE;
                    end else if (iter_next == limit) begin
                        converged <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        // Drain guarantees no write-back lands this cycle,
                        // so clearing here cannot drop a parity bit.
                        syndrome <= 1'b0;
                        row      <= '0;
                        state    <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnu_row_scheduler.sv
// tb_cnu_row_scheduler
//
// Directed and randomized scenarios for cnu_row_scheduler with NROWS=4 and
// CNU_LAT=7. For each scenario the bench precomputes the expected per-cycle
// trace from a row-issue schedule (which rows go out on which cycle, when
// each comes back, when the iteration is evaluated) and compares every
// output on every cycle.
module tb_cnu_row_scheduler;

    localparam int N   = 4;
    localparam int LAT = 7;
    localparam int AW  = 6;
    localparam int IW  = 5;
    localparam int L   = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] max_iter;
    logic          hold;
    logic          row_parity;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          cnu_vld;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          converged;
    logic [IW-1:0] iter_count;

    int checks = 0;
    int errors = 0;

    // Stimulus per scenario cycle.
    logic          hold_a  [L];
    logic          start_a [L];
    logic          rst_a   [L];
    logic          par_a   [L];
    logic [IW-1:0] mi_a    [L];
    // Expected outputs per scenario cycle.
    int e_rd [L], e_ra [L], e_wr [L], e_wa [L];
    int e_busy [L], e_done [L], e_conv [L], e_iter [L];
    // Parity of each row in each iteration.
    bit pmat [16][N];

    int prev_conv = 0;
    int prev_iter = 0;
    int len;
    int done_cyc;

    cnu_row_scheduler #(.NROWS(N), .AW(AW), .CNU_LAT(LAT), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .max_iter   (max_iter),
        .hold       (hold),
        .row_parity (row_parity),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .cnu_vld    (cnu_vld),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Fresh stimulus: no hold, no start, reset released, random don't-care
    // parity and iteration limit (both must be ignored where not sampled).
    task automatic clear_stim();
        for (int c = 0; c < L; c++) begin
            hold_a[c]  = 1'b0;
            start_a[c] = 1'b0;
            rst_a[c]   = 1'b1;
            par_a[c]   = 1'($urandom_range(0, 1));
            mi_a[c]    = IW'($urandom_range(0, 31));
        end
        for (int i = 0; i < 16; i++)
            for (int r = 0; r < N; r++)
                pmat[i][r] = 1'b0;
    endtask

    // Reference model: walk the issue schedule row by row.
    task automatic build(input int s, input int lim_in, input int rst_cyc);
        int lim, t, it, issued, last, eval_c, w;
        bit syn;
        for (int c = 0; c < L; c++) begin
            e_rd[c] = 0; e_ra[c] = 0; e_wr[c] = 0; e_wa[c] = 0;
            e_busy[c] = 0; e_done[c] = 0;
            e_conv[c] = (c <= s) ? prev_conv : 0;
            e_iter[c] = (c <= s) ? prev_iter : 0;
        end
        start_a[s] = 1'b1;
        mi_a[s]    = IW'(lim_in);
        lim = (lim_in == 0) ? 1 : lim_in;
        t  = s + 1;
        it = 0;
        forever begin
            issued = 0;
            last   = 0;
            syn    = 1'b0;
            while (issued < N) begin
                if (!hold_a[t]) begin
                    e_rd[t] = 1;
                    e_ra[t] = issued;
                    w = t + LAT + 1;
                    e_wr[w] = 1;
                    e_wa[w] = issued;
                    par_a[w] = pmat[it][issued];
                    syn |= pmat[it][issued];
                    last = t;
                    issued++;
                end
                t++;
            end
            eval_c = last + LAT + 2;   // one cycle after the last write-back
            it++;
            for (int c = eval_c + 1; c < L; c++) e_iter[c] = it;
            if (!syn) begin
                for (int c = eval_c + 1; c < L; c++) e_conv[c] = 1;
                break;
            end
            if (it == lim) break;
            t = eval_c + 1;
        end
        done_cyc = eval_c + 1;
        for (int c = s + 1; c <= done_cyc; c++) e_busy[c] = 1;
        e_done[done_cyc] = 1;
        len = done_cyc + 3;
        prev_conv = e_conv[done_cyc];
        prev_iter = e_iter[done_cyc];
        if (rst_cyc >= 0) begin
            rst_a[rst_cyc] = 1'b0;
            for (int c = rst_cyc + 1; c < L; c++) begin
                e_rd[c] = 0; e_ra[c] = 0; e_wr[c] = 0; e_wa[c] = 0;
                e_busy[c] = 0; e_done[c] = 0; e_conv[c] = 0; e_iter[c] = 0;
            end
            len = rst_cyc + 12;
            prev_conv = 0;
            prev_iter = 0;
        end
    endtask

    // Drive one cycle after each rising edge, check at the falling edge.
    task automatic run(input string name);
        for (int c = 0; c < len; c++) begin
            start      = start_a[c];
            hold       = hold_a[c];
            rst        = rst_a[c];
            row_parity = par_a[c];
            max_iter   = mi_a[c];
            @(negedge clk);
            check({name, ".rd_en"},      c, 32'(rd_en),      32'(e_rd[c]));
            check({name, ".rd_addr"},    c, 32'(rd_addr),    32'(e_ra[c]));
            check({name, ".cnu_vld"},    c, 32'(cnu_vld),    (c > 0) ? 32'(e_rd[c-1]) : 32'd0);
            check({name, ".wr_en"},      c, 32'(wr_en),      32'(e_wr[c]));
            check({name, ".wr_addr"},    c, 32'(wr_addr),    32'(e_wa[c]));
            check({name, ".busy"},       c, 32'(busy),       32'(e_busy[c]));
            check({name, ".done"},       c, 32'(done),       32'(e_done[c]));
            check({name, ".converged"},  c, 32'(converged),  32'(e_conv[c]));
            check({name, ".iter_count"}, c, 32'(iter_count), 32'(e_iter[c]));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int s, lim;

        start = 1'b0; hold = 1'b0; row_parity = 1'b0; max_iter = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with start and hold asserted to show reset wins.
        start = 1'b1; hold = 1'b1; row_parity = 1'b1;
        @(negedge clk);
        check("reset.rd_en",      0, 32'(rd_en),      32'd0);
        check("reset.cnu_vld",    0, 32'(cnu_vld),    32'd0);
        check("reset.wr_en",      0, 32'(wr_en),      32'd0);
        check("reset.wr_addr",    0, 32'(wr_addr),    32'd0);
        check("reset.busy",       0, 32'(busy),       32'd0);
        check("reset.done",       0, 32'(done),       32'd0);
        check("reset.converged",  0, 32'(converged),  32'd0);
        check("reset.iter_count", 0, 32'(iter_count), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; hold = 1'b0;

        // Clean single iteration: converges, done at cycle 14.
        clear_stim();
        build(0, 3, -1);
        check("plan1.done_cycle", 0, 32'(done_cyc), 32'd14);
        run("plan1");

        // Row 2 always odd: three back-to-back iterations, limit reached.
        clear_stim();
        for (int i = 0; i < 16; i++) pmat[i][2] = 1'b1;
        build(0, 3, -1);
        run("plan2");

        // Hold during cycles 2-4: done slips to cycle 17.
        clear_stim();
        hold_a[2] = 1'b1; hold_a[3] = 1'b1; hold_a[4] = 1'b1;
        build(0, 3, -1);
        check("plan3.done_cycle", 0, 32'(done_cyc), 32'd17);
        run("plan3");

        // Reset in the middle of drain, then a normal decode.
        clear_stim();
        build(0, 3, 10);
        run("plan4_rst");
        clear_stim();
        build(0, 3, -1);
        run("plan4_after");

        // max_iter=0 behaves as a single iteration.
        clear_stim();
        for (int i = 0; i < 16; i++)
            for (int r = 0; r < N; r++) pmat[i][r] = 1'b1;
        build(0, 0, -1);
        run("plan5");

        // start pulsed while busy is ignored.
        clear_stim();
        build(0, 3, -1);
        start_a[6] = 1'b1;
        run("plan6");

        // Randomized scenarios: holds, parity, limits, spurious starts.
        for (int k = 0; k < 8; k++) begin
            clear_stim();
            s   = $urandom_range(0, 3);
            lim = $urandom_range(0, 4);
            for (int c = 0; c < L; c++) hold_a[c] = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < 16; i++)
                for (int r = 0; r < N; r++) pmat[i][r] = ($urandom_range(0, 3) == 0);
            build(s, lim, -1);
            for (int j = 0; j < 2; j++) start_a[$urandom_range(s + 1, done_cyc)] = 1'b1;
            run("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
